// File: rtl/multicycle_control_fsm_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm_if
// Bundle between the multi-cycle sequencer and the MIPS datapath/memory.
//   opcode_i, mem_ready_i      : datapath/memory -> sequencer
//   pc_write*/i_or_d/mem_*     : PC and shared memory port control
//   ir_write/reg_*/mem_to_reg  : instruction and register file control
//   alu_src_*/alu_op/pc_source : shared ALU and PC mux control
//   instr_done/illegal_op/bus_err/state : status and debug
// Modports: slave = sequencer, master = datapath side (or a testbench).
// ---------------------------------------------------------------------------
interface multicycle_control_fsm_if;
  logic [5:0] opcode_i;
  logic       mem_ready_i;
  logic       pc_write_o;
  logic       pc_write_cond_eq_o;
  logic       pc_write_cond_ne_o;
  logic       i_or_d_o;
  logic       mem_read_o;
  logic       mem_write_o;
  logic       ir_write_o;
  logic       reg_write_o;
  logic [1:0] reg_dst_o;
  logic [1:0] mem_to_reg_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [3:0] alu_op_o;
  logic [1:0] pc_source_o;
  logic       instr_done_o;
  logic       illegal_op_o;
  logic       bus_err_o;
  logic [3:0] state_o;

  modport slave (
    input  opcode_i, mem_ready_i,
    output pc_write_o, pc_write_cond_eq_o, pc_write_cond_ne_o, i_or_d_o,
           mem_read_o, mem_write_o, ir_write_o, reg_write_o, reg_dst_o,
           mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_source_o,
           instr_done_o, illegal_op_o, bus_err_o, state_o
  );

  modport master (
    output opcode_i, mem_ready_i,
    input  pc_write_o, pc_write_cond_eq_o, pc_write_cond_ne_o, i_or_d_o,
           mem_read_o, mem_write_o, ir_write_o, reg_write_o, reg_dst_o,
           mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_source_o,
           instr_done_o, illegal_op_o, bus_err_o, state_o
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
// Moore-style multi-cycle sequencer for the MIPS core. Steps each instruction
// through fetch/decode/execute/memory/writeback, time-sharing one memory
// port and one ALU. Memory states wait on mem_ready_i with a timeout trap;
// unknown opcodes trap as illegal.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave modport of multicycle_control_fsm_if (opcode, ready,
//           all datapath controls, sticky traps, debug state)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RESET    | one idle cycle after reset release
// FETCH    | read instruction at PC, PC <= PC+4 on ready
// DECODE   | ALUOut <= branch target, dispatch on opcode
// EXEC_R   | R-type ALU operation (funct driven)
// EXEC_I   | immediate ALU operation
// ALU_WB   | write ALUOut to rd (R-type) or rt (immediate)
// MEM_ADDR | ALUOut <= A + sign-ext imm
// MEM_RD   | data read at ALUOut, waits on ready
// MEM_WB   | write MDR to rt
// MEM_WR   | data write at ALUOut, waits on ready
// BRANCH   | compare A-B, conditional PC load from ALUOut
// JUMP     | PC <= jump target
// JAL      | $31 <= PC, PC <= jump target
// TRAP     | illegal opcode or bus timeout, holds until reset
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAIT_W       = 4
) (
  input logic                     clk,
  input logic                     reset,
  multicycle_control_fsm_if.slave bus
);

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_ALU_WB   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_WAIT_MAX);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              illegal_q, illegal_d;
  logic              bus_err_q, bus_err_d;

  logic       pc_write, cond_eq, cond_ne, i_or_d, mem_read, mem_write;
  logic       ir_write, reg_write, alu_src_a, instr_done;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic [3:0] alu_op;
  logic       in_wait;
  logic       timeout;

  logic [5:0] op;
  logic       rdy;
  assign op  = bus.opcode_i;
  assign rdy = bus.mem_ready_i;

  // Ready on the limit cycle still wins because timeout requires !rdy.
  assign timeout = (MEM_WAIT_MAX != 0) && !rdy && (wait_q == WAIT_LIM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_RESET;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    in_wait    = 1'b0;
    pc_write   = 1'b0;
    cond_eq    = 1'b0;
    cond_ne    = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 4'b0000;
    pc_source  = 2'b00;
    instr_done = 1'b0;

    case (state_q)
      S_RESET: state_d = S_FETCH;

      S_FETCH: begin
        in_wait   = 1'b1;
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = rdy;
        pc_write  = rdy;
        if (rdy) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end

      S_DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          6'h00:                      state_d = S_EXEC_R;
          6'h08, 6'h0d, 6'h0f, 6'h0c: state_d = S_EXEC_I;
          6'h23, 6'h2b:               state_d = S_MEM_ADDR;
          6'h04, 6'h05:               state_d = S_BRANCH;
          6'h02:                      state_d = S_JUMP;
          6'h03:                      state_d = S_JAL;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end

      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 4'b1111;
        state_d   = S_ALU_WB;
      end

      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (op)
          6'h0d:   alu_op = 4'b0001;
          6'h0f:   alu_op = 4'b0010;
          6'h0c:   alu_op = 4'b0011;
          default: alu_op = 4'b0000;
        endcase
        state_d = S_ALU_WB;
      end

      S_ALU_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op == 6'h00) ? 2'b01 : 2'b00;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op == 6'h23) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        in_wait  = 1'b1;
        i_or_d   = 1'b1;
        mem_read = 1'b1;
        if (rdy) begin
          state_d = S_MEM_WB;
        end else if (timeout) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WR: begin
        in_wait   = 1'b1;
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        if (rdy) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (timeout) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end

      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 4'b0110;
        pc_source  = 2'b01;
        cond_eq    = (op == 6'h04);
        cond_ne    = (op == 6'h05);
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      // Register file takes PC (already PC+4) at the same edge the PC loads.
      S_JAL: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_TRAP:  state_d = S_TRAP;

      default: state_d = S_RESET;
    endcase
  end

  // Counter restarts on every state change so each memory state gets a full
  // wait budget; saturates so a disabled timeout never wraps.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (in_wait && !rdy && (wait_q != '1)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  assign bus.pc_write_o         = pc_write;
  assign bus.pc_write_cond_eq_o = cond_eq;
  assign bus.pc_write_cond_ne_o = cond_ne;
  assign bus.i_or_d_o           = i_or_d;
  assign bus.mem_read_o         = mem_read;
  assign bus.mem_write_o        = mem_write;
  assign bus.ir_write_o         = ir_write;
  assign bus.reg_write_o        = reg_write;
  assign bus.reg_dst_o          = reg_dst;
  assign bus.mem_to_reg_o       = mem_to_reg;
  assign bus.alu_src_a_o        = alu_src_a;
  assign bus.alu_src_b_o        = alu_src_b;
  assign bus.alu_op_o           = alu_op;
  assign bus.pc_source_o        = pc_source;
  assign bus.instr_done_o       = instr_done;
  assign bus.illegal_op_o       = illegal_q;
  assign bus.bus_err_o          = bus_err_q;
  assign bus.state_o            = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_fsm
// Directed bench for the multi-cycle sequencer: a per-cycle vector table of
// {opcode, ready, expected state, expected controls}, followed by hand
// sequences for the wait-state timeout, its boundary, and async reset.
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       pcw, ceq, cne, iord, mrd, mwr, irw, rgw;
    logic [1:0] rdst, m2r;
    logic       srca;
    logic [1:0] srcb;
    logic [3:0] aluop;
    logic [1:0] pcsrc;
    logic       done, ill, berr;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    logic       rdy;
    logic [3:0] st;
    ctl_t       ctl;
  } vec_t;

  localparam logic [3:0] RST = 4'd0, FET = 4'd1, DEC = 4'd2, EXR = 4'd3,
                         EXI = 4'd4, AWB = 4'd5, MAD = 4'd6, MRD = 4'd7,
                         MWB = 4'd8, MWR = 4'd9, BRA = 4'd10, JMP = 4'd11,
                         JAL = 4'd12, TRP = 4'd13;

  localparam ctl_t C_ZERO     = '0;
  localparam ctl_t C_FETCH_W  = '{mrd:1'b1, srcb:2'b01, default:'0};
  localparam ctl_t C_FETCH_R  = '{mrd:1'b1, srcb:2'b01, irw:1'b1, pcw:1'b1, default:'0};
  localparam ctl_t C_DECODE   = '{srcb:2'b11, default:'0};
  localparam ctl_t C_EXEC_R   = '{srca:1'b1, aluop:4'b1111, default:'0};
  localparam ctl_t C_EXEC_ORI = '{srca:1'b1, srcb:2'b10, aluop:4'b0001, default:'0};
  localparam ctl_t C_EXEC_LUI = '{srca:1'b1, srcb:2'b10, aluop:4'b0010, default:'0};
  localparam ctl_t C_AWB_R    = '{rgw:1'b1, rdst:2'b01, done:1'b1, default:'0};
  localparam ctl_t C_AWB_I    = '{rgw:1'b1, done:1'b1, default:'0};
  localparam ctl_t C_MEMADDR  = '{srca:1'b1, srcb:2'b10, default:'0};
  localparam ctl_t C_MEMRD    = '{iord:1'b1, mrd:1'b1, default:'0};
  localparam ctl_t C_MEMWB    = '{rgw:1'b1, m2r:2'b01, done:1'b1, default:'0};
  localparam ctl_t C_MEMWR_W  = '{iord:1'b1, mwr:1'b1, default:'0};
  localparam ctl_t C_MEMWR_R  = '{iord:1'b1, mwr:1'b1, done:1'b1, default:'0};
  localparam ctl_t C_BEQ      = '{srca:1'b1, aluop:4'b0110, pcsrc:2'b01, ceq:1'b1, done:1'b1, default:'0};
  localparam ctl_t C_BNE      = '{srca:1'b1, aluop:4'b0110, pcsrc:2'b01, cne:1'b1, done:1'b1, default:'0};
  localparam ctl_t C_JUMP     = '{pcw:1'b1, pcsrc:2'b10, done:1'b1, default:'0};
  localparam ctl_t C_JAL      = '{pcw:1'b1, pcsrc:2'b10, rgw:1'b1, rdst:2'b10, m2r:2'b10, done:1'b1, default:'0};
  localparam ctl_t C_TRAP_ILL = '{ill:1'b1, default:'0};
  localparam ctl_t C_TRAP_BE  = '{berr:1'b1, default:'0};

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm #(.MEM_WAIT_MAX(15), .WAIT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t sample_ctl();
    ctl_t c;
    c.pcw   = bus.pc_write_o;
    c.ceq   = bus.pc_write_cond_eq_o;
    c.cne   = bus.pc_write_cond_ne_o;
    c.iord  = bus.i_or_d_o;
    c.mrd   = bus.mem_read_o;
    c.mwr   = bus.mem_write_o;
    c.irw   = bus.ir_write_o;
    c.rgw   = bus.reg_write_o;
    c.rdst  = bus.reg_dst_o;
    c.m2r   = bus.mem_to_reg_o;
    c.srca  = bus.alu_src_a_o;
    c.srcb  = bus.alu_src_b_o;
    c.aluop = bus.alu_op_o;
    c.pcsrc = bus.pc_source_o;
    c.done  = bus.instr_done_o;
    c.ill   = bus.illegal_op_o;
    c.berr  = bus.bus_err_o;
    return c;
  endfunction

  task automatic chk(input string name, input int idx, input logic [3:0] st,
                     input ctl_t exp);
    ctl_t act;
    act = sample_ctl();
    n_checks++;
    if (bus.state_o !== st) begin
      n_fail++;
      $display("FAIL %s[%0d] state: got %0d expected %0d", name, idx, bus.state_o, st);
    end
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] controls: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                     input ctl_t c);
    vec_t v;
    v.op = op; v.rdy = rdy; v.st = st; v.ctl = c;
    vecs.push_back(v);
  endtask

  // Inputs change at the falling edge; outputs are checked 1 time unit later.
  task automatic apply(input string name, input int idx, input logic [5:0] op,
                       input logic rdy, input logic [3:0] st, input ctl_t c);
    @(negedge clk);
    bus.opcode_i    = op;
    bus.mem_ready_i = rdy;
    #1;
    chk(name, idx, st, c);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  // Assert reset between edges and check everything clears without a clock.
  task automatic async_reset_check(input string name);
    #2 reset = 1'b0;
    #1 chk(name, 0, RST, C_ZERO);
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    reset           = 1'b0;
    bus.opcode_i    = 6'h00;
    bus.mem_ready_i = 1'b1;

    // R-type: states 0,1,2,3,5 then back to FETCH
    add(6'h00, 1'b1, RST, C_ZERO);
    add(6'h00, 1'b1, FET, C_FETCH_R);
    add(6'h00, 1'b1, DEC, C_DECODE);
    add(6'h00, 1'b1, EXR, C_EXEC_R);
    add(6'h00, 1'b1, AWB, C_AWB_R);
    // lw with 3 wait cycles: 8 cycles FETCH to FETCH
    add(6'h23, 1'b1, FET, C_FETCH_R);
    add(6'h23, 1'b1, DEC, C_DECODE);
    add(6'h23, 1'b1, MAD, C_MEMADDR);
    add(6'h23, 1'b0, MRD, C_MEMRD);
    add(6'h23, 1'b0, MRD, C_MEMRD);
    add(6'h23, 1'b0, MRD, C_MEMRD);
    add(6'h23, 1'b1, MRD, C_MEMRD);
    add(6'h23, 1'b1, MWB, C_MEMWB);
    // sw with one wait cycle
    add(6'h2b, 1'b1, FET, C_FETCH_R);
    add(6'h2b, 1'b1, DEC, C_DECODE);
    add(6'h2b, 1'b1, MAD, C_MEMADDR);
    add(6'h2b, 1'b0, MWR, C_MEMWR_W);
    add(6'h2b, 1'b1, MWR, C_MEMWR_R);
    // ori
    add(6'h0d, 1'b1, FET, C_FETCH_R);
    add(6'h0d, 1'b1, DEC, C_DECODE);
    add(6'h0d, 1'b1, EXI, C_EXEC_ORI);
    add(6'h0d, 1'b1, AWB, C_AWB_I);
    // beq, bne
    add(6'h04, 1'b1, FET, C_FETCH_R);
    add(6'h04, 1'b1, DEC, C_DECODE);
    add(6'h04, 1'b1, BRA, C_BEQ);
    add(6'h05, 1'b1, FET, C_FETCH_R);
    add(6'h05, 1'b1, DEC, C_DECODE);
    add(6'h05, 1'b1, BRA, C_BNE);
    // j, jal
    add(6'h02, 1'b1, FET, C_FETCH_R);
    add(6'h02, 1'b1, DEC, C_DECODE);
    add(6'h02, 1'b1, JMP, C_JUMP);
    add(6'h03, 1'b1, FET, C_FETCH_R);
    add(6'h03, 1'b1, DEC, C_DECODE);
    add(6'h03, 1'b1, JAL, C_JAL);
    // lui with a fetch wait
    add(6'h0f, 1'b0, FET, C_FETCH_W);
    add(6'h0f, 1'b1, FET, C_FETCH_R);
    add(6'h0f, 1'b1, DEC, C_DECODE);
    add(6'h0f, 1'b1, EXI, C_EXEC_LUI);
    add(6'h0f, 1'b1, AWB, C_AWB_I);
    // illegal opcode traps and holds
    add(6'h3f, 1'b1, FET, C_FETCH_R);
    add(6'h3f, 1'b1, DEC, C_DECODE);
    add(6'h3f, 1'b1, TRP, C_TRAP_ILL);
    add(6'h00, 1'b1, TRP, C_TRAP_ILL);
    add(6'h00, 1'b0, TRP, C_TRAP_ILL);

    // reset held low with ready high: everything stays zero
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 chk("reset_hold", 0, RST, C_ZERO);

    release_reset();
    for (int i = 0; i < vecs.size(); i++)
      apply("vec", i, vecs[i].op, vecs[i].rdy, vecs[i].st, vecs[i].ctl);
    async_reset_check("reset_from_trap");

    // 16 not-ready fetch cycles -> bus error
    release_reset();
    apply("berr", 0, 6'h00, 1'b0, RST, C_ZERO);
    for (int k = 1; k <= 16; k++)
      apply("berr", k, 6'h00, 1'b0, FET, C_FETCH_W);
    apply("berr", 17, 6'h00, 1'b1, TRP, C_TRAP_BE);
    apply("berr", 18, 6'h00, 1'b1, TRP, C_TRAP_BE);
    async_reset_check("reset_from_berr");

    // ready arrives on the 16th cycle: no error, then reset mid-MEM_RD
    release_reset();
    apply("edge", 0, 6'h23, 1'b0, RST, C_ZERO);
    for (int k = 1; k <= 15; k++)
      apply("edge", k, 6'h23, 1'b0, FET, C_FETCH_W);
    apply("edge", 16, 6'h23, 1'b1, FET, C_FETCH_R);
    apply("edge", 17, 6'h23, 1'b1, DEC, C_DECODE);
    apply("edge", 18, 6'h23, 1'b1, MAD, C_MEMADDR);
    apply("edge", 19, 6'h23, 1'b0, MRD, C_MEMRD);
    apply("edge", 20, 6'h23, 1'b0, MRD, C_MEMRD);
    async_reset_check("reset_mid_memrd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle sequencer for the MIPS core. It replaces the single-cycle opcode decoder with a Moore-style state machine that steps each instruction through fetch, decode, execute, memory and writeback over 3-5 cycles. One shared memory port and one shared ALU are time-multiplexed between instruction fetch, address calculation and data access. The block handles memory wait-states through a ready handshake, and traps on illegal opcodes and memory timeouts.

Parameters:
MEM_WAIT_MAX, 15, max consecutive not-ready cycles in a memory state before bus-error trap; 0 disables the timeout
WAIT_W, 4, width of wait counter; must hold MEM_WAIT_MAX

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset
opcode_i  input  6  opcode from instruction register, stable from DECODE until next FETCH
mem_ready_i  input  1  memory completes access in the cycle sampled high
pc_write_o  output  1  unconditional PC load
pc_write_cond_eq_o  output  1  PC load if ALU zero
pc_write_cond_ne_o  output  1  PC load if ALU not zero
i_or_d_o  output  1  memory address: 0=PC, 1=ALUOut
mem_read_o  output  1  memory read request
mem_write_o  output  1  memory write request
ir_write_o  output  1  instruction register load
reg_write_o  output  1  register file write
reg_dst_o  output  2  00=rt, 01=rd, 10=$31
mem_to_reg_o  output  2  00=ALUOut, 01=MDR, 10=PC
alu_src_a_o  output  1  0=PC, 1=A
alu_src_b_o  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=imm<<2
alu_op_o  output  4  0000 add, 0001 or, 0010 lui, 0011 and, 0110 sub, 1111 R-type (funct)
pc_source_o  output  2  00=ALU result, 01=ALUOut, 10=jump target
instr_done_o  output  1  one-cycle pulse on the cycle an instruction retires
illegal_op_o  output  1  sticky: illegal-opcode trap
bus_err_o  output  1  sticky: memory timeout trap
state_o  output  4  current state encoding, for debug

Behaviour:
- State register: 4 bits, encodings 0-13 in the order RESET, FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, JAL, TRAP.
- Outputs are decoded from state and opcode_i. Any output not listed for a state is 0.
- Reset asserted, including mid-instruction: state=RESET, wait counter=0, sticky flags=0, all outputs 0 immediately.
- RESET lasts one cycle after deassert, then goes to FETCH.
- FETCH: mem_read=1, i_or_d=0, src_a=0, src_b=01, alu_op=0000, pc_source=00.
  - ir_write and pc_write = mem_ready_i.
  - Advances to DECODE when ready=1; otherwise holds with mem_read held high.
- DECODE: src_a=0, src_b=11, alu_op=0000, precomputing the branch target. Next state by opcode:
  - 0x00 -> EXEC_R
  - 0x08/0x0d/0x0f/0x0c -> EXEC_I
  - 0x23/0x2b -> MEM_ADDR
  - 0x04/0x05 -> BRANCH
  - 0x02 -> JUMP
  - 0x03 -> JAL
  - otherwise -> TRAP with illegal_op set
- EXEC_R: src_a=1, src_b=00, alu_op=1111; next ALU_WB.
- EXEC_I: src_a=1, src_b=10; alu_op addi 0000, ori 0001, lui 0010, andi 0011; next ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=00, reg_dst=01 if opcode 0x00 else 00; next FETCH.
- MEM_ADDR: src_a=1, src_b=10, alu_op=0000; next MEM_RD for 0x23, MEM_WR for 0x2b.
- MEM_RD: i_or_d=1, mem_read=1; ready -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=01, reg_dst=00; next FETCH.
- MEM_WR: i_or_d=1, mem_write=1; ready -> FETCH.
- BRANCH: src_a=1, src_b=00, alu_op=0110, pc_source=01; cond_eq=1 for 0x04, cond_ne=1 for 0x05; next FETCH.
- JUMP: pc_write=1, pc_source=10; next FETCH.
- JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10; next FETCH. The register file captures PC+4 before the PC updates at the same edge.
- TRAP: all control outputs 0; holds until reset.
- Wait counter, used in FETCH/MEM_RD/MEM_WR:
  - Cleared on entering any of these states.
  - Increments each cycle ready=0.
  - If ready=0 and counter==MEM_WAIT_MAX (and MEM_WAIT_MAX != 0): go to TRAP, set bus_err.
  - ready=1 on the limit cycle wins: normal advance, no error.
- instr_done_o=1 on the cycle leaving ALU_WB, MEM_WB, BRANCH, JUMP, JAL, or MEM_WR with ready=1.
- Zero-wait latency per instruction: R/I-ALU 4 cycles, lw 5, sw 4, branch 3, j/jal 3.

Test Plan:
- Release reset, ready=1, opcode 0x00 -> states 0,1,2,3,5,1. ALU_WB shows reg_write=1, reg_dst=01, alu_op=1111 in EXEC_R. One instr_done pulse.
- opcode 0x23, ready low 3 cycles in MEM_RD -> mem_read, i_or_d=1 held 4 cycles. MEM_WB shows mem_to_reg=01, reg_dst=00. Total 8 cycles FETCH-to-FETCH.
- opcode 0x2b -> mem_write=1 only in MEM_WR; reg_write never 1. opcode 0x0d -> EXEC_I alu_op=0001, src_b=10.
- opcode 0x04 then 0x05 -> BRANCH alu_op=0110, pc_source=01, cond_eq=1 / cond_ne=1 respectively. 3 cycles each.
- opcode 0x03 -> JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10.
- Traps and reset:
  - opcode 0x3f -> TRAP after DECODE, illegal_op=1 held.
  - FETCH with ready=0 for 16 cycles -> bus_err=1.
  - ready rising exactly on the 16th cycle -> no error.
  - Reset low mid-MEM_RD -> all outputs and flags 0 without a clock edge.
